// File: rtl/prescaled_counter.sv
// rtl/prescaled_counter.sv - programmable prescaler driving an up/down modulo counter
// with synchronous load and registered step (TICK) and wrap (TC) pulses.
module prescaled_counter #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 22
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 CE,
  input  logic [DIV_WIDTH-1:0] DIV,
  input  logic                 UP,
  input  logic [WIDTH-1:0]     MAX,
  input  logic                 LD,
  input  logic [WIDTH-1:0]     LDVAL,
  output logic [WIDTH-1:0]     O,
  output logic                 TICK,
  output logic                 TC
);

  logic [DIV_WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]     o_q, o_d;
  logic                 tick_q, tick_d;
  logic                 tc_q, tc_d;
  logic                 step;
  logic                 wrap;

  // >= rather than == so lowering DIV below the running count forces a step
  assign step = CE && (p_q >= DIV);

  // Out-of-range values (O > MAX after MAX is lowered) count as a wrap either way
  assign wrap = UP ? (o_q >= MAX) : ((o_q == '0) || (o_q > MAX));

  always_comb begin
    p_d    = p_q;
    o_d    = o_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;

    if (LD) begin
      p_d = '0;
      o_d = (LDVAL > MAX) ? MAX : LDVAL;
    end else if (step) begin
      p_d    = '0;
      tick_d = 1'b1;
      tc_d   = wrap;
      if (UP) begin
        o_d = wrap ? '0 : o_q + WIDTH'(1);
      end else begin
        o_d = wrap ? MAX : o_q - WIDTH'(1);
      end
    end else if (CE) begin
      p_d = p_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      p_q    <= '0;
      o_q    <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      p_q    <= p_d;
      o_q    <= o_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  assign O    = o_q;
  assign TICK = tick_q;
  assign TC   = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// tb/tb_prescaled_counter.sv - directed vectors with a scoreboard queue and
// a decoupled monitor for prescaled_counter.
module tb_prescaled_counter;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        CE = 1'b0;
  logic [21:0] DIV = 22'd3;
  logic        UP = 1'b1;
  logic [7:0]  MAX = 8'd255;
  logic        LD = 1'b0;
  logic [7:0]  LDVAL = 8'd0;
  logic [7:0]  O;
  logic        TICK;
  logic        TC;

  prescaled_counter #(.WIDTH(8), .DIV_WIDTH(22)) dut (
    .CLK(CLK), .RESETN(RESETN), .CE(CE), .DIV(DIV), .UP(UP), .MAX(MAX),
    .LD(LD), .LDVAL(LDVAL), .O(O), .TICK(TICK), .TC(TC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] o;
    logic       tick;
    logic       tc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  event sample_ev;

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK or sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if ({O, TICK, TC} !== {e.o, e.tick, e.tc}) begin
          n_err++;
          $display("FAIL %s: got O=%0d TICK=%0b TC=%0b, expected O=%0d TICK=%0b TC=%0b",
                   e.name, O, TICK, TC, e.o, e.tick, e.tc);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] eo, input logic et, input logic etc, input string nm);
    exp_t e;
    e.o = eo; e.tick = et; e.tc = etc; e.name = nm;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, then queue what must be visible after the edge
  task automatic vec(input logic ce, input logic [21:0] div, input logic up, input logic [7:0] max,
                     input logic ld, input logic [7:0] ldval,
                     input logic [7:0] eo, input logic et, input logic etc, input string nm);
    CE = ce; DIV = div; UP = up; MAX = max; LD = ld; LDVAL = ldval;
    @(posedge CLK);
    push_exp(eo, et, etc, nm);
    @(negedge CLK);
  endtask

  initial begin
    #3;
    push_exp(8'd0, 1'b0, 1'b0, "reset_state");
    ->sample_ev;
    @(negedge CLK);
    RESETN = 1'b1;

    // 1: DIV=3 -> one step every 4 enabled cycles
    for (int k = 1; k <= 12; k++)
      vec(1, 3, 1, 255, 0, 0, 8'(k / 4), (k % 4) == 0, 0, "t1_count");
    vec(1, 3, 1, 255, 1, 254, 254, 0, 0, "t1_load254");
    for (int k = 1; k <= 8; k++)
      vec(1, 3, 1, 255, 0, 0, (k < 4) ? 8'd254 : (k < 8) ? 8'd255 : 8'd0,
          (k == 4) || (k == 8), k == 8, "t1_wrap255");
    vec(1, 3, 1, 255, 0, 0, 0, 0, 0, "t1_after_wrap");

    // 2: DIV=0, modulo-10 up count
    vec(1, 0, 1, 9, 1, 0, 0, 0, 0, "t2_load0");
    for (int k = 1; k <= 12; k++)
      vec(1, 0, 1, 9, 0, 0, 8'(k % 10), 1, k == 10, "t2_mod10");

    // 3: down count and direction reversal
    vec(1, 0, 0, 9, 1, 0, 0, 0, 0, "t3_load0");
    vec(1, 0, 0, 9, 0, 0, 9, 1, 1, "t3_wrap_down");
    vec(1, 0, 0, 9, 0, 0, 8, 1, 0, "t3_down8");
    vec(1, 0, 0, 9, 0, 0, 7, 1, 0, "t3_down7");
    vec(1, 0, 1, 9, 0, 0, 8, 1, 0, "t3_reverse_up");
    vec(1, 0, 1, 9, 0, 0, 9, 1, 0, "t3_up9");
    vec(1, 0, 0, 9, 0, 0, 8, 1, 0, "t3_reverse_down");

    // 4: load behaviour
    vec(0, 0, 1, 255, 1, 8'h2A, 8'h2A, 0, 0, "t4_load_ce0");
    vec(0, 0, 1, 255, 0, 0, 8'h2A, 0, 0, "t4_hold_ce0");
    vec(0, 0, 1, 100, 1, 200, 100, 0, 0, "t4_load_clamp");
    vec(1, 0, 1, 100, 1, 7, 7, 0, 0, "t4_load_vs_wrap_step");
    vec(1, 2, 1, 100, 0, 0, 7, 0, 0, "t4_p_cleared_1");
    vec(1, 2, 1, 100, 0, 0, 7, 0, 0, "t4_p_cleared_2");
    vec(1, 2, 1, 100, 0, 0, 8, 1, 0, "t4_p_cleared_step");

    // 5: MAX and DIV lowered below current state
    vec(0, 0, 1, 255, 1, 200, 200, 0, 0, "t5_load200_a");
    vec(1, 0, 1, 100, 0, 0, 0, 1, 1, "t5_max_lowered_up");
    vec(0, 0, 1, 255, 1, 200, 200, 0, 0, "t5_load200_b");
    vec(1, 0, 0, 100, 0, 0, 100, 1, 1, "t5_max_lowered_down");
    vec(1, 1000, 1, 255, 1, 10, 10, 0, 0, "t5_load10");
    for (int k = 1; k <= 500; k++)
      vec(1, 1000, 1, 255, 0, 0, 10, 0, 0, "t5_p_climb");
    vec(0, 2, 1, 255, 0, 0, 10, 0, 0, "t5_div_lowered_ce0");
    vec(1, 2, 1, 255, 0, 0, 11, 1, 0, "t5_div_lowered_step");
    vec(1, 2, 1, 255, 0, 0, 11, 0, 0, "t5_resync_1");
    vec(1, 2, 1, 255, 0, 0, 11, 0, 0, "t5_resync_2");
    vec(1, 2, 1, 255, 0, 0, 12, 1, 0, "t5_resync_step");

    // 6: short reset pulse while TICK is high
    #1 RESETN = 1'b0;
    #1;
    push_exp(8'd0, 1'b0, 1'b0, "t6_async_clear");
    ->sample_ev;
    #1 RESETN = 1'b1;
    for (int k = 1; k <= 4; k++)
      vec(1, 3, 1, 255, 0, 0, (k == 4) ? 8'd1 : 8'd0, k == 4, 0, "t6_restart");

    repeat (3) @(negedge CLK);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prescaled_counter.md
Name: prescaled_counter

Overview:
- Parametrised successor to the fixed prescaler-plus-clock-enabled counter pair used for LED and timebase generation.
- Combines the following in one block:
  - a programmable prescaler;
  - an up/down modulo counter of configurable width;
  - a synchronous load;
  - registered step and terminal-count pulses.
- Sits between the board clock and any slow consumer: LED drivers, UART baud ticks, debounce timers.
- Multiple instances can be chained: TC of one instance drives CE of the next.

Parameters:
- WIDTH, 8, width of the main counter O, LDVAL and MAX.
- DIV_WIDTH, 22, width of the prescaler counter and DIV.

Ports:
- CLK  in  1  system clock; all state is rising-edge triggered.
- RESETN  in  1  asynchronous active-low reset.
- CE  in  1  count enable; gates the prescaler.
- DIV  in  DIV_WIDTH  prescale divisor; the counter steps once every DIV+1 enabled cycles.
- UP  in  1  direction: 1 = count up, 0 = count down.
- MAX  in  WIDTH  terminal value; the counter range is 0..MAX.
- LD  in  1  synchronous load strobe.
- LDVAL  in  WIDTH  load value.
- O  out  WIDTH  counter value (registered).
- TICK  out  1  one-cycle pulse, registered, each time O is stepped.
- TC  out  1  one-cycle pulse, registered, each time O wraps.

Behaviour:
- Reset (RESETN=0, asynchronous, immediate): O=0, prescaler P=0, TICK=0, TC=0. Outputs hold these values until the first rising CLK edge after RESETN deasserts.
- Internal step = CE & (P >= DIV). Combinational, not exported.
- Prescaler P, per edge, in priority order:
  - LD=1: P <= 0.
  - step: P <= 0.
  - CE=1: P <= P+1.
  - else: P holds.
- DIV=0 gives step on every cycle with CE=1.
- Using >= guarantees a step and resync when DIV is lowered below the current P.
- Main counter O, per edge, in priority order:
  1. LD=1: O <= LDVAL, regardless of CE. If LDVAL > MAX, O <= MAX (clamp).
  2. step & UP: O <= (O >= MAX) ? 0 : O+1.
  3. step & !UP: O <= (O == 0 || O > MAX) ? MAX : O-1.
  4. else: O holds.
- All arithmetic is modulo 2^WIDTH.
- MAX = 2^WIDTH-1 gives a plain binary counter. MAX=0 holds O at 0, with TC on every step.
- TICK <= step & !LD. Asserted in the cycle in which the new O value is visible.
- TC <= step & !LD & wrap. wrap is taken from the same edge as the O update:
  - up: O >= MAX.
  - down: O == 0 or O > MAX.
- TC and TICK are aligned: TC=1 implies TICK=1.
- LD and step in the same cycle: load wins; TICK=0, TC=0, P cleared.
- CE=0: P, O, TICK=0 and TC=0 all hold, except that LD still loads.
- UP, MAX and DIV may change any cycle; they take effect on the next edge with no glitch or extra pulse.
- Reset mid-count aborts immediately; there is no pending-pulse carry-over.
- Latency:
  - CE rising with DIV=0: O changes at the first edge.
  - LD to O: one edge.
- Expected RTL size: 120–400 lines.

Test Plan:
1. Reset, then WIDTH=8, DIV=3, MAX=255, UP=1, CE=1 held -> O is 0,0,0,0,1,... and steps every 4 cycles; TICK has period 4, high for 1 cycle; TC stays 0 until O 255->0, then pulses once.
2. DIV=0, MAX=9, UP=1, CE=1 -> O counts 0..9,0 on consecutive cycles; TC=1 exactly in the cycle O shows 0 after 9; period is 10.
3. DIV=0, MAX=9, UP=0, start O=0 -> next O=9 with TC=1, then 8,7,...; toggling UP mid-run reverses at the next step with no skipped value.
4. CE=0, LD=1, LDVAL=0x2A -> O=0x2A next cycle with TICK=0. Then LDVAL=200 with MAX=100 -> O=100. LD coincident with a step -> O=LDVAL, TICK=0, TC=0, P=0.
5. O=200, MAX lowered to 100, UP=1, step -> O=0 with TC=1. Same setup with UP=0 -> O=100 with TC=1. DIV lowered from 1000 to 2 while P=500 -> step on the next CE cycle.
6. RESETN pulsed low for less than a clock period mid-count with CE=1 -> O, TICK and TC clear asynchronously; counting restarts from 0 with P=0, and the first step arrives DIV+1 cycles after release.
